usb3_scram_ctrl: RTL and testbench



---
 rtl/usb3_scram_pkg.sv | 23 ++
 rtl/usb3_scram_ctrl_if.sv | 28 ++
 rtl/usb3_lfsr.sv | 50 +++++
 rtl/usb3_scram_ctrl.sv | 139 +++++++++++++
 tb/tb_usb3_scram_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/usb3_scram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb3_scram_pkg
// Description : Shared types and constants for the USB 3.0 TX scrambler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package usb3_scram_pkg;

    localparam int          c_lane_w    = 8;
    localparam int          c_lanes     = 4;
    localparam int          c_word_w    = c_lane_w * c_lanes;
    localparam logic [7:0]  c_com_byte  = 8'hBC;   // K28.5
    localparam logic [7:0]  c_skp_byte  = 8'h3C;   // K28.1
    localparam logic [15:0] c_lfsr_seed = 16'h7DBD;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        WAIT_COM = 2'd1,
        ACTIVE   = 2'd2
    } scram_state_t;

endpackage
`default_nettype wire

// File: rtl/usb3_scram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usb3_scram_ctrl_if
// Description : TX word stream in/out of the scrambler sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb3_scram_ctrl_if;
    import usb3_scram_pkg::*;

    logic [c_word_w-1:0] in_data;
    logic [c_lanes-1:0]  in_datak;
    logic                in_valid;
    logic [c_word_w-1:0] out_data;
    logic [c_lanes-1:0]  out_datak;
    logic                out_valid;

    modport master (
        output in_data, in_datak, in_valid,
        input  out_data, out_datak, out_valid
    );

    modport slave (
        input  in_data, in_datak, in_valid,
        output out_data, out_datak, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/usb3_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : usb3_lfsr
// Description : 32-bit-per-clock USB 3.0 scrambler, x^16+x^5+x^4+x^3+1.
// Revision    : 1.0 - initial release
// ============================================================================
module usb3_lfsr
    import usb3_scram_pkg::*;
#(
    parameter logic [15:0] SEED = c_lfsr_seed
) (
    input  wire logic                clock,
    input  wire logic                reset_n,
    input  wire logic                scram_en,
    input  wire logic                scram_rst,
    input  wire logic [c_word_w-1:0] data_in,
    output logic      [c_word_w-1:0] data_out
);

    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_next;
    logic [c_word_w-1:0] w_keystream;

    // Keystream bit j is the MSB before the j-th shift; data is LSB first.
    always_comb begin
        logic [15:0] v_s;
        v_s         = r_lfsr;
        w_keystream = '0;
        for (int j = 0; j < c_word_w; j++) begin
            w_keystream[j] = v_s[15];
            v_s            = {v_s[14:0], 1'b0} ^ (v_s[15] ? 16'h0039 : 16'h0000);
        end
        w_lfsr_next = v_s;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr   <= SEED;
            data_out <= '0;
        end else begin
            data_out <= data_in ^ w_keystream;
            if (scram_rst)
                r_lfsr <= SEED;
            else if (scram_en)
                r_lfsr <= w_lfsr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb3_scram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb3_scram_ctrl
// Description : TX scrambler sequencer: LFSR reset/advance/hold and K/D merge.
// Revision    : 1.0 - initial release
// ============================================================================
module usb3_scram_ctrl
    import usb3_scram_pkg::*;
#(
    parameter bit         ALIGN_CHECK = 1'b1,
    parameter logic [7:0] COM_BYTE    = c_com_byte,
    parameter logic [7:0] SKP_BYTE    = c_skp_byte
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    usb3_scram_ctrl_if.slave   bus,
    input  wire logic          scram_disable,
    input  wire logic          err_clr,
    output logic               synced,
    output logic               err_align
);

    scram_state_t r_state, w_state_next;
    logic w_com, w_skp, w_misalign;
    logic w_scram_en, w_scram_rst;

    logic [c_word_w-1:0] r_data;
    logic [c_lanes-1:0]  r_datak;
    logic                r_valid;
    logic                r_scrambled;
    logic [c_word_w-1:0] w_lfsr_out;
    logic [c_word_w-1:0] w_merged;

    always_comb begin
        w_com = bus.in_valid && bus.in_datak[0] && (bus.in_data[7:0] == COM_BYTE);
        w_skp = bus.in_valid && (bus.in_datak == 4'hF);
        for (int i = 0; i < c_lanes; i++) begin
            if (bus.in_data[i*c_lane_w +: c_lane_w] != SKP_BYTE)
                w_skp = 1'b0;
        end
    end

    generate
        if (ALIGN_CHECK) begin : g_align_on
            always_comb begin
                w_misalign = 1'b0;
                for (int i = 1; i < c_lanes; i++) begin
                    if (bus.in_valid && bus.in_datak[i] &&
                        (bus.in_data[i*c_lane_w +: c_lane_w] == COM_BYTE))
                        w_misalign = 1'b1;
                end
            end
        end else begin : g_align_off
            assign w_misalign = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= DISABLED;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_scram_en   = 1'b0;
        w_scram_rst  = 1'b0;
        case (r_state)
            DISABLED: begin
                if (!scram_disable)
                    w_state_next = WAIT_COM;
            end
            WAIT_COM: begin
                if (w_com) begin
                    w_scram_rst  = 1'b1;
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_com)
                    w_scram_rst = 1'b1;
                else if (!w_skp && bus.in_valid)
                    w_scram_en = 1'b1;
            end
            default: w_state_next = DISABLED;
        endcase
        // Disable overrides everything, including a same-cycle COM.
        if (scram_disable) begin
            w_state_next = DISABLED;
            w_scram_en   = 1'b0;
            w_scram_rst  = 1'b0;
        end
    end

    usb3_lfsr #(.SEED(c_lfsr_seed)) u_lfsr (
        .clock     (clock),
        .reset_n   (reset_n),
        .scram_en  (w_scram_en),
        .scram_rst (w_scram_rst),
        .data_in   (bus.in_data),
        .data_out  (w_lfsr_out)
    );

    // Raw word and flags are delayed one clock to line up with the LFSR output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_datak     <= '0;
            r_valid     <= 1'b0;
            r_scrambled <= 1'b0;
            synced      <= 1'b0;
            err_align   <= 1'b0;
        end else begin
            r_data      <= bus.in_data;
            r_datak     <= bus.in_datak;
            r_valid     <= bus.in_valid;
            r_scrambled <= w_scram_en;
            synced      <= (w_state_next == ACTIVE);
            if (err_clr)
                err_align <= 1'b0;
            else if (w_misalign)
                err_align <= 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < c_lanes; i++) begin : g_lane
            assign w_merged[i*c_lane_w +: c_lane_w] = (r_scrambled && !r_datak[i]) ?
                w_lfsr_out[i*c_lane_w +: c_lane_w] : r_data[i*c_lane_w +: c_lane_w];
        end
    endgenerate

    assign bus.out_data  = w_merged;
    assign bus.out_datak = r_datak;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_usb3_scram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb3_scram_ctrl
// Description : Directed plus random stimulus against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb3_scram_ctrl;

    logic clock;
    logic reset_n;
    logic scram_disable;
    logic err_clr;
    logic synced;
    logic err_align;

    usb3_scram_ctrl_if bus ();

    usb3_scram_ctrl #(
        .ALIGN_CHECK (1'b1),
        .COM_BYTE    (8'hBC),
        .SKP_BYTE    (8'h3C)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .scram_disable (scram_disable),
        .err_clr       (err_clr),
        .synced        (synced),
        .err_align     (err_align)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: link mode 0 = off, 1 = hunting for COM, 2 = locked.
    int          m_mode;
    int unsigned m_lfsr;
    logic [31:0] e_data;
    logic [3:0]  e_datak;
    logic        e_valid;
    logic        e_synced;
    logic        e_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Polynomial view of the scrambler: shift left, reduce modulo 0x10039.
    function automatic logic [31:0] ks_word(input int unsigned seed);
        int unsigned s;
        logic [31:0] ks;
        s = seed;
        for (int j = 0; j < 32; j++) begin
            ks[j] = s[15];
            s = s << 1;
            if (s[16]) s = s ^ 32'h10039;
        end
        return ks;
    endfunction

    function automatic int unsigned ks_advance(input int unsigned seed);
        int unsigned s;
        s = seed;
        for (int j = 0; j < 32; j++) begin
            s = s << 1;
            if (s[16]) s = s ^ 32'h10039;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_lfsr   = 32'h7DBD;
        e_data   = '0;
        e_datak  = '0;
        e_valid  = 1'b0;
        e_synced = 1'b0;
        e_err    = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        check_val({ctx, ".data"},   bus.out_data,  e_data);
        check_val({ctx, ".datak"},  {28'd0, bus.out_datak}, {28'd0, e_datak});
        check_val({ctx, ".valid"},  {31'd0, bus.out_valid}, {31'd0, e_valid});
        check_val({ctx, ".synced"}, {31'd0, synced},        {31'd0, e_synced});
        check_val({ctx, ".err"},    {31'd0, err_align},     {31'd0, e_err});
    endtask

    // Called at a falling edge; applies one word, steps the model across the
    // rising edge, checks 1 ns later, returns at the next falling edge.
    task automatic cycle(input string ctx, input logic [31:0] d, input logic [3:0] k,
                         input logic v, input logic dis, input logic clr);
        logic is_com, is_skp, misal, scr;
        logic [31:0] ks;
        bus.in_data   = d;
        bus.in_datak  = k;
        bus.in_valid  = v;
        scram_disable = dis;
        err_clr       = clr;

        is_com = v && k[0] && (d[7:0] == 8'hBC);
        is_skp = v && (k == 4'hF) && (d == 32'h3C3C3C3C);
        misal  = 1'b0;
        for (int i = 1; i < 4; i++)
            if (v && k[i] && (d[8*i +: 8] == 8'hBC)) misal = 1'b1;
        scr = !dis && (m_mode == 2) && v && !is_com && !is_skp;

        ks = ks_word(m_lfsr);
        for (int i = 0; i < 4; i++)
            e_data[8*i +: 8] = (scr && !k[i]) ? (d[8*i +: 8] ^ ks[8*i +: 8]) : d[8*i +: 8];
        e_datak = k;
        e_valid = v;

        if (!dis && (m_mode != 0) && is_com) m_lfsr = 32'h7DBD;
        else if (scr)                        m_lfsr = ks_advance(m_lfsr);

        if (dis)                       m_mode = 0;
        else if (m_mode == 0)          m_mode = 1;
        else if (m_mode == 1 && is_com) m_mode = 2;
        e_synced = (m_mode == 2);

        if (clr)        e_err = 1'b0;
        else if (misal) e_err = 1'b1;

        @(posedge clock);
        #1;
        check_outputs(ctx);
        @(negedge clock);
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        logic        v, dis, clr;
        int          kind;

        reset_n       = 1'b0;
        scram_disable = 1'b1;
        err_clr       = 1'b0;
        bus.in_data   = '0;
        bus.in_datak  = '0;
        bus.in_valid  = 1'b0;
        model_reset();

        #3;
        check_outputs("reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        cycle("first_raw", 32'h12345678, 4'h0, 1, 0, 0);
        cycle("com",       32'h4A4A4ABC, 4'h1, 1, 0, 0);
        cycle("seed_word", 32'h00000000, 4'h0, 1, 0, 0);
        cycle("data1",     32'hDEADBEEF, 4'h0, 1, 0, 0);
        cycle("skp",       32'h3C3C3C3C, 4'hF, 1, 0, 0);
        cycle("after_skp", 32'h00000000, 4'h0, 1, 0, 0);
        cycle("idle",      32'hCAFEF00D, 4'h0, 0, 0, 0);
        cycle("lane2_k",   32'h11FE2233, 4'h4, 1, 0, 0);
        cycle("dis_com",   32'h4A4A4ABC, 4'h1, 1, 1, 0);
        cycle("dis_data",  32'h55AA55AA, 4'h0, 1, 0, 0);
        cycle("recom",     32'h000000BC, 4'h1, 1, 0, 0);
        cycle("reseed",    32'h00000000, 4'h0, 1, 0, 0);
        cycle("misalign",  32'h00BC0000, 4'h4, 1, 0, 0);
        cycle("err_hold",  32'h01020304, 4'h0, 1, 0, 0);
        cycle("err_clr",   32'h01020304, 4'h0, 1, 0, 1);
        cycle("pre_rst",   32'h99999999, 4'h0, 1, 0, 0);
        mid_reset();
        cycle("post_rst",  32'h87654321, 4'h0, 1, 0, 0);
        cycle("post_rst2", 32'h87654321, 4'h0, 1, 0, 0);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 19);
            v    = 1'b1;
            d    = $urandom;
            k    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if (kind < 2) begin
                d[7:0] = 8'hBC; k = 4'h1;
            end else if (kind < 4) begin
                d = 32'h3C3C3C3C; k = 4'hF;
            end else if (kind < 6) begin
                v = 1'b0;
            end else if (kind == 6) begin
                d[8*$urandom_range(1, 3) +: 8] = 8'hBC; k = 4'hE;
            end
            dis = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 14) == 0);
            cycle("rand", d, k, v, dis, clr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d", n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
